// File: rtl/regfile_scoreboard_if.sv
// Register-file bus for regfile_scoreboard: writeback, issue and two read ports.
// AW must equal $clog2(DEPTH) of the attached register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             LD_REG;
    logic [AW-1:0]    DR;
    logic [WIDTH-1:0] Data;
    logic             ISSUE;
    logic [AW-1:0]    ISSUE_DR;
    logic [AW-1:0]    SR1;
    logic [AW-1:0]    SR2;
    logic [WIDTH-1:0] SR1_out;
    logic [WIDTH-1:0] SR2_out;
    logic             SR1_busy;
    logic             SR2_busy;
    logic             DOUBLE_ISSUE;

    modport master (
        output LD_REG, DR, Data, ISSUE, ISSUE_DR, SR1, SR2,
        input  SR1_out, SR2_out, SR1_busy, SR2_busy, DOUBLE_ISSUE
    );

    modport slave (
        input  LD_REG, DR, Data, ISSUE, ISSUE_DR, SR1, SR2,
        output SR1_out, SR2_out, SR1_busy, SR2_busy, DOUBLE_ISSUE
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// LC-3 register file: one write port, two registered read ports, pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge writes/pending updates to the read ports.
module regfile_scoreboard #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0
) (
    input  logic Clk,
    input  logic Reset,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_next;
    logic             r_double;
    logic             w_wr_en;
    logic             w_iss_en;
    logic             w_double;

    logic [AW-1:0]    w_sr     [2];
    logic [WIDTH-1:0] r_rd_data [2];
    logic             r_rd_busy [2];

    // Address 0 is inert when hardwired to zero: writes and issues to it vanish.
    assign w_wr_en  = bus.LD_REG && !((ZERO_R0 != 0) && (bus.DR == '0));
    assign w_iss_en = bus.ISSUE  && !((ZERO_R0 != 0) && (bus.ISSUE_DR == '0));

    // A same-edge writeback to the issued register retires the old entry first.
    assign w_double = w_iss_en && r_pend[bus.ISSUE_DR]
                      && !(w_wr_en && (bus.DR == bus.ISSUE_DR));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            assign w_pend_next[gi] = (w_iss_en && (bus.ISSUE_DR == AW'(gi))) ? 1'b1 :
                                     (w_wr_en  && (bus.DR       == AW'(gi))) ? 1'b0 :
                                     r_pend[gi];

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_mem[gi] <= '0;
                end else if (w_wr_en && (bus.DR == AW'(gi))) begin
                    r_mem[gi] <= bus.Data;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pend   <= '0;
            r_double <= 1'b0;
        end else begin
            r_pend   <= w_pend_next;
            r_double <= r_double | w_double;
        end
    end

    assign w_sr[0] = bus.SR1;
    assign w_sr[1] = bus.SR2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [WIDTH-1:0] w_rd_raw;
            logic             w_rd_pend;
            logic             w_rd_zero;

`ifdef REGFILE_BYPASS_EN
            assign w_rd_raw  = (w_wr_en && (bus.DR == w_sr[gi])) ? bus.Data : r_mem[w_sr[gi]];
            assign w_rd_pend = w_pend_next[w_sr[gi]];
`else
            assign w_rd_raw  = r_mem[w_sr[gi]];
            assign w_rd_pend = r_pend[w_sr[gi]];
`endif
            assign w_rd_zero = (ZERO_R0 != 0) && (w_sr[gi] == '0);

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_rd_data[gi] <= '0;
                    r_rd_busy[gi] <= 1'b0;
                end else begin
                    r_rd_data[gi] <= w_rd_zero ? '0 : w_rd_raw;
                    r_rd_busy[gi] <= w_rd_zero ? 1'b0 : w_rd_pend;
                end
            end
        end
    endgenerate

    assign bus.SR1_out      = r_rd_data[0];
    assign bus.SR2_out      = r_rd_data[1];
    assign bus.SR1_busy     = r_rd_busy[0];
    assign bus.SR2_busy     = r_rd_busy[1];
    assign bus.DOUBLE_ISSUE = r_double;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset/ZERO_R0 sequences, random vs model.
// Two instances: default (16x8) and ZERO_R0=1 (32x16).
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        ld;
        logic [4:0]  dr;
        logic [31:0] data;
        logic        iss;
        logic [4:0]  idr;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
    } stim_t;

    typedef struct packed {
        logic [31:0] o1;
        logic        b1;
        logic [31:0] o2;
        logic        b2;
        logic        dbl;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t e;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    regfile_scoreboard_if #(.WIDTH(16), .AW(3)) bus0 ();
    regfile_scoreboard_if #(.WIDTH(32), .AW(4)) bus1 ();

    regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0));
    regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural registers, pending set and error flag per instance.
    logic [31:0] m_mem  [2][16];
    logic [15:0] m_pend [2];
    logic        m_dbl  [2];
    resp_t       m_out  [2];
    int          m_depth [2] = '{8, 16};
    bit          m_zero  [2] = '{1'b0, 1'b1};
    logic [31:0] m_mask  [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

    stim_t st [2];
    stim_t idle = '0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
            m_pend[k] = '0;
            m_dbl[k]  = 1'b0;
            m_out[k]  = '0;
        end
    endfunction

    function automatic void model_step(int k, stim_t s);
        bit          we, ie;
        logic [15:0] p_new;
        logic [4:0]  a;
        logic [31:0] d;
        logic        b;
        we = s.ld  && !(m_zero[k] && s.dr  == 5'd0);
        ie = s.iss && !(m_zero[k] && s.idr == 5'd0);
        p_new = m_pend[k];
        if (we) p_new[s.dr]  = 1'b0;
        if (ie) p_new[s.idr] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a = (r == 0) ? s.sr1 : s.sr2;
            if (BYP) begin
                d = (we && s.dr == a) ? (s.data & m_mask[k]) : m_mem[k][a];
                b = p_new[a];
            end else begin
                d = m_mem[k][a];
                b = m_pend[k][a];
            end
            if (m_zero[k] && a == 5'd0) begin
                d = '0;
                b = 1'b0;
            end
            if (r == 0) begin m_out[k].o1 = d; m_out[k].b1 = b; end
            else        begin m_out[k].o2 = d; m_out[k].b2 = b; end
        end
        if (ie && m_pend[k][s.idr] && !(we && s.dr == s.idr)) m_dbl[k] = 1'b1;
        m_out[k].dbl = m_dbl[k];
        if (we) m_mem[k][s.dr] = s.data & m_mask[k];
        m_pend[k] = p_new;
    endfunction

    function automatic resp_t dut_resp(int k);
        resp_t r;
        if (k == 0) begin
            r.o1 = {16'h0, bus0.SR1_out}; r.b1 = bus0.SR1_busy;
            r.o2 = {16'h0, bus0.SR2_out}; r.b2 = bus0.SR2_busy;
            r.dbl = bus0.DOUBLE_ISSUE;
        end else begin
            r.o1 = bus1.SR1_out; r.b1 = bus1.SR1_busy;
            r.o2 = bus1.SR2_out; r.b2 = bus1.SR2_busy;
            r.dbl = bus1.DOUBLE_ISSUE;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_resp(string tag, resp_t act, resp_t exp);
        chk({tag, ".SR1_out"},  act.o1, exp.o1);
        chk({tag, ".SR1_busy"}, 32'(act.b1), 32'(exp.b1));
        chk({tag, ".SR2_out"},  act.o2, exp.o2);
        chk({tag, ".SR2_busy"}, 32'(act.b2), 32'(exp.b2));
        chk({tag, ".DOUBLE"},   32'(act.dbl), 32'(exp.dbl));
    endtask

    task automatic drive();
        bus0.LD_REG = st[0].ld;  bus0.DR = st[0].dr[2:0];  bus0.Data = st[0].data[15:0];
        bus0.ISSUE = st[0].iss;  bus0.ISSUE_DR = st[0].idr[2:0];
        bus0.SR1 = st[0].sr1[2:0]; bus0.SR2 = st[0].sr2[2:0];
        bus1.LD_REG = st[1].ld;  bus1.DR = st[1].dr[3:0];  bus1.Data = st[1].data;
        bus1.ISSUE = st[1].iss;  bus1.ISSUE_DR = st[1].idr[3:0];
        bus1.SR1 = st[1].sr1[3:0]; bus1.SR2 = st[1].sr2[3:0];
    endtask

    // One clock: drive, predict, edge, then compare both instances against the model.
    task automatic cycle(string tag);
        drive();
        model_step(0, st[0]);
        model_step(1, st[1]);
        @(posedge Clk);
        #1;
        chk_resp({tag, ".d0"}, dut_resp(0), m_out[0]);
        chk_resp({tag, ".d1"}, dut_resp(1), m_out[1]);
        $display("%s: d0 o1=%h b1=%0d o2=%h b2=%0d dbl=%0d", tag, bus0.SR1_out, bus0.SR1_busy,
                 bus0.SR2_out, bus0.SR2_busy, bus0.DOUBLE_ISSUE);
    endtask

    task automatic pulse_reset(string tag);
        Reset = 1'b1;
        #1;
        model_reset();
        chk_resp({tag, ".d0"}, dut_resp(0), m_out[0]);
        chk_resp({tag, ".d1"}, dut_resp(1), m_out[1]);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    function automatic vec_t mk(bit ld, int dr, logic [31:0] data, bit iss, int idr, int sr1, int sr2,
                                logic [31:0] o1, bit b1, logic [31:0] o2, bit b2, bit dbl);
        vec_t v;
        v.s.ld = ld; v.s.dr = 5'(dr); v.s.data = data; v.s.iss = iss; v.s.idr = 5'(idr);
        v.s.sr1 = 5'(sr1); v.s.sr2 = 5'(sr2);
        v.e.o1 = o1; v.e.b1 = b1; v.e.o2 = o2; v.e.b2 = b2; v.e.dbl = dbl;
        return v;
    endfunction

    function automatic stim_t rand_stim(int k);
        stim_t s;
        int    top = m_depth[k] - 1;
        s.ld   = 1'($urandom_range(0, 1));
        s.dr   = 5'($urandom_range(0, top));
        s.data = $urandom;
        s.iss  = ($urandom_range(0, 2) == 0);
        s.idr  = ($urandom_range(0, 3) == 0) ? s.dr : 5'($urandom_range(0, top));
        s.sr1  = ($urandom_range(0, 3) == 0) ? s.dr : 5'($urandom_range(0, top));
        s.sr2  = ($urandom_range(0, 3) == 0) ? s.idr : 5'($urandom_range(0, top));
        return s;
    endfunction

    vec_t tbl [11];

    initial begin
        tbl[0]  = mk(1, 5, 32'hBEEF, 0, 0, 5, 7, BYP ? 32'hBEEF : 32'h0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,    0, 0, 5, 5, 32'hBEEF, 0, 32'hBEEF, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,    1, 2, 0, 2, 32'h0, 0, 32'h0, BYP, 0);
        tbl[3]  = mk(0, 0, 32'h0,    0, 0, 0, 2, 32'h0, 0, 32'h0, 1, 0);
        tbl[4]  = mk(1, 2, 32'h1234, 0, 0, 0, 2, 32'h0, 0, BYP ? 32'h1234 : 32'h0, !BYP, 0);
        tbl[5]  = mk(0, 0, 32'h0,    0, 0, 0, 2, 32'h0, 0, 32'h1234, 0, 0);
        tbl[6]  = mk(1, 4, 32'h00AA, 1, 4, 4, 2, BYP ? 32'h00AA : 32'h0, BYP, 32'h1234, 0, 0);
        tbl[7]  = mk(0, 0, 32'h0,    0, 0, 4, 2, 32'h00AA, 1, 32'h1234, 0, 0);
        tbl[8]  = mk(0, 0, 32'h0,    1, 4, 4, 2, 32'h00AA, 1, 32'h1234, 0, 1);
        tbl[9]  = mk(1, 4, 32'h0055, 0, 0, 4, 2, BYP ? 32'h0055 : 32'h00AA, !BYP, 32'h1234, 0, 1);
        tbl[10] = mk(0, 0, 32'h0,    0, 0, 4, 5, 32'h0055, 0, 32'hBEEF, 0, 1);

        Reset = 1'b1;
        st[0] = idle;
        st[1] = idle;
        drive();
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        chk_resp("reset.d0", dut_resp(0), m_out[0]);
        chk_resp("reset.d1", dut_resp(1), m_out[1]);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            st[0] = tbl[i].s;
            st[1] = idle;
            cycle($sformatf("tbl%0d", i));
            chk_resp($sformatf("tbl%0d.vec", i), dut_resp(0), tbl[i].e);
        end

        // Mid-cycle reset with a write in flight: outputs clear at once, write is lost.
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk_resp("midrst.d0", dut_resp(0), m_out[0]);
        st[0] = mk(1, 3, 32'h7777, 1, 3, 3, 7, 0, 0, 0, 0, 0).s;
        drive();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        st[0] = mk(0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0).s;
        cycle("postrst");
        chk("postrst.SR1_out", dut_resp(0).o1, 32'h0);
        chk("postrst.SR1_busy", 32'(bus0.SR1_busy), 32'h0);

        // Hardwired R0 on the 32x16 instance, then the top address.
        st[0] = idle;
        st[1] = mk(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0).s;
        cycle("zr0.wr");
        st[1] = mk(1, 15, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0).s;
        cycle("zr0.rd");
        chk("zr0.SR1_out", bus1.SR1_out, 32'h0);
        chk("zr0.SR1_busy", 32'(bus1.SR1_busy), 32'h0);
        chk("zr0.DOUBLE", 32'(bus1.DOUBLE_ISSUE), 32'h0);
        st[1] = mk(0, 0, 0, 1, 0, 15, 15, 0, 0, 0, 0, 0).s;
        cycle("zr15.rd");
        chk("zr15.SR1_out", bus1.SR1_out, 32'hCAFE_F00D);
        chk("zr15.SR2_out", bus1.SR2_out, 32'hCAFE_F00D);
        chk("zr0.DOUBLE2", 32'(bus1.DOUBLE_ISSUE), 32'h0);

        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) pulse_reset($sformatf("rrst%0d", i));
            st[0] = rand_stim(0);
            st[1] = rand_stim(1);
            cycle($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the pipelined LC-3 datapath. It provides one write port, two registered read ports and a per-register pending-write scoreboard. The decode stage reads operands and marks destinations as in flight. The writeback stage retires them. Width, depth and an optional hardwired-zero R0 are set by parameters; write-to-read forwarding is selected at compile time.

## Interface
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; power of two, 2..32. Address width AW = $clog2(DEPTH), a localparam.
- ZERO_R0, 0, when 1, register 0 reads as zero, ignores writes and is never marked pending.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- LD_REG  in  1  writeback strobe; writes Data into register DR and clears its pending bit.
- DR  in  AW  writeback destination address.
- Data  in  WIDTH  writeback data.
- ISSUE  in  1  decode strobe; sets the pending bit of ISSUE_DR.
- ISSUE_DR  in  AW  address being marked in flight.
- SR1, SR2  in  AW  read addresses, sampled every cycle.
- SR1_out, SR2_out  out  WIDTH  registered read data.
- SR1_busy, SR2_busy  out  1  registered pending status of SR1 and SR2.
- DOUBLE_ISSUE  out  1  sticky error flag; set on ISSUE to an already-pending register.

## Operation
- Storage is DEPTH x WIDTH flops, plus a DEPTH-bit pending vector.
- Reset (async): all registers 0, pending vector 0, SR1_out, SR2_out, SR1_busy, SR2_busy and DOUBLE_ISSUE all 0. Deassertion takes effect on the next edge. Reset during an in-flight write discards the write.
- Write: when LD_REG=1 at an edge, reg[DR] <= Data and pending[DR] <= 0, unless the same-edge issue rule below applies. Writing a non-pending register is legal; its pending bit stays 0.
- Issue: when ISSUE=1 at an edge, pending[ISSUE_DR] <= 1.
  - If ISSUE_DR is already pending, DOUBLE_ISSUE <= 1. The flag holds until Reset. The bit stays 1; the scoreboard tracks one outstanding write per register.
- Same-edge LD_REG and ISSUE to the same address: the data is written and the pending bit ends at 1, because issue wins. DOUBLE_ISSUE is not set, since that write retires the old entry.
- Read: every edge, SRn_out <= reg[SRn] and SRn_busy <= pending[SRn], using values before the edge's update. The exception is the forwarding build; see Configuration.
- SR1 and SR2 may be equal; both ports then return identical data.
- ZERO_R0=1:
  - LD_REG with DR=0 is dropped.
  - ISSUE with ISSUE_DR=0 is dropped, with no flag.
  - Reads of address 0 return data 0 and busy 0.

## Timing
- Read latency: 1 cycle. Address is presented at edge N-1; data and busy are valid after edge N.
- Write visibility: data written at edge N is returned by a read whose address is sampled at edge N+1, or at edge N in the forwarding build.
- Pending set at edge N is visible on SRn_busy after edge N+1, or after edge N in the forwarding build.
- No handshake back-pressure; every strobe is accepted in its cycle.
- All outputs are flop outputs; there is no combinational input-to-output path.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: on a same-edge read and write to one address, SRn_out captures Data and SRn_busy captures the post-update pending value. An issue to the same address forces busy to 1.
- Undefined: reads capture pre-edge contents and pending bits, so same-cycle read-during-write returns the old value.
- ZERO_R0 masking applies in both builds.

## Test plan
- Reset then read: assert Reset mid-cycle, set SR1=3 and SR2=7 → all outputs 0 immediately, then SR1_out = SR2_out = 0x0000 and busy = 0 on the following edges.
- Write/read: at edge 1 LD_REG, DR=5, Data=0xBEEF; SR1=5 at edge 2 → SR1_out=0xBEEF after edge 2. Repeat with SR1=5 at edge 1 → old value 0x0000 without the macro, 0xBEEF with REGFILE_BYPASS_EN.
- Scoreboard: ISSUE DR=2, then read SR2=2 → SR2_busy=1. Then LD_REG DR=2, Data=0x1234 → next read shows SR2_busy=0 and SR2_out=0x1234.
- Collision: same edge LD_REG DR=4, Data=0x00AA and ISSUE ISSUE_DR=4 → reg4=0x00AA, pending4=1, DOUBLE_ISSUE=0. A second ISSUE to 4 → DOUBLE_ISSUE=1 and stays 1 until Reset.
- ZERO_R0=1, WIDTH=32, DEPTH=16: LD_REG DR=0, Data=0xFFFFFFFF plus ISSUE 0 → SR1=0 reads 0x00000000 with busy 0. Then DR=15 is written and read back correctly, confirming the top address.
